// File: rtl/fixed_point_square_pkg.sv
// Shared sizes and state encodings for the serial fixed-point squarer.
package fixed_point_square_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned SCALE      = 17;
    localparam int unsigned LONG_WIDTH = 64;
    localparam int unsigned CNT_WIDTH  = $clog2(WIDTH);

    localparam logic [1:0] SQ_IDLE = 2'd0;
    localparam logic [1:0] SQ_ITER = 2'd1;
    localparam logic [1:0] SQ_DONE = 2'd2;

endpackage

// File: rtl/fixed_point_square_if.sv
// Start/operand request and busy/result response of the squarer.
interface fixed_point_square_if;
    import fixed_point_square_pkg::*;

    logic                  iInputReady;
    logic [WIDTH-1:0]      Operand;
    logic                  oBusy;
    logic                  OutputReady;
    logic [LONG_WIDTH-1:0] Result;

    modport master (
        output iInputReady,
        output Operand,
        input  oBusy,
        input  OutputReady,
        input  Result
    );

    modport slave (
        input  iInputReady,
        input  Operand,
        output oBusy,
        output OutputReady,
        output Result
    );

endinterface

// File: rtl/fixed_point_square_ffd.sv
// Rising-edge flop with synchronous active-high reset and load enable,
// same shape as the output stage flop of the sqrt unit.
module fixed_point_square_ffd #(
    parameter int unsigned Size = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Enable,
    input  logic [Size-1:0] D,
    output logic [Size-1:0] Q
);

    // Reset has priority over a load.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (Enable) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/fixed_point_square.sv
// Serial shift-add squarer: one multiplier bit per cycle, exact |x|^2 >> SCALE.
module fixed_point_square
    import fixed_point_square_pkg::*;
(
    input logic                 Clock,
    input logic                 Reset,
    fixed_point_square_if.slave sq
);

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]      mplier_q, mplier_d;
    logic [2*WIDTH-1:0]    acc_q, acc_d;

    logic [WIDTH-1:0]      magnitude;
    logic [2*WIDTH-1:0]    partial;
    logic                  last_iter;
    logic [LONG_WIDTH-1:0] result_d;

    // Two's complement negate keeps 0x8000_0000 as 2^31 when read unsigned.
    assign magnitude = sq.Operand[WIDTH-1] ? (~sq.Operand + WIDTH'(1)) : sq.Operand;
    assign partial   = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    assign last_iter = (state_q == SQ_ITER) && (cnt_q == CNT_WIDTH'(WIDTH - 1));
    assign result_d  = LONG_WIDTH'(acc_d >> SCALE);
    assign sq.oBusy  = (state_q == SQ_ITER);

    // Next-state logic for the FSM, bit counter and shift-add datapath.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        unique case (state_q)
            SQ_IDLE, SQ_DONE: begin
                state_d = SQ_IDLE;
                if (sq.iInputReady) begin
                    state_d  = SQ_ITER;
                    cnt_d    = '0;
                    mcand_d  = magnitude;
                    mplier_d = magnitude;
                    acc_d    = '0;
                end
            end
            SQ_ITER: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + partial;
                end
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_WIDTH'(1);
                if (last_iter) begin
                    state_d = SQ_DONE;
                end
            end
            default: state_d = SQ_IDLE;
        endcase
    end

    // Control and datapath state; reset clears everything and aborts a running op.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= SQ_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // Result only loads on the final iteration, so partial sums never show.
    fixed_point_square_ffd #(
        .Size (LONG_WIDTH)
    ) u_result_ffd (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (last_iter),
        .D      (result_d),
        .Q      (sq.Result)
    );

    // Completion pulse lines up with the DONE state.
    fixed_point_square_ffd #(
        .Size (1)
    ) u_ready_ffd (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (1'b1),
        .D      (last_iter),
        .Q      (sq.OutputReady)
    );

endmodule
